// File: rtl/ghostchip_pkg.sv
// Shared keypad geometry and scan-state encoding
// for the keypad scanner slice.
package ghostchip_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int NUM_KEYS = KEY_ROWS * KEY_COLS;
  localparam int ROW_W    = $clog2(KEY_ROWS);
  localparam int CODE_W   = $clog2(NUM_KEYS);

  typedef enum logic {
    SCAN   = 1'b0,
    COMMIT = 1'b1
  } scan_state_e;

  function automatic logic [KEY_ROWS-1:0] row_drive(
    input logic [ROW_W-1:0] r
  );
    return ~(KEY_ROWS'(1) << r);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Physical keypad pins plus the debounced
// key state presented to the cpu.
interface keypad_scanner_if;
  import ghostchip_pkg::*;

  logic [KEY_ROWS-1:0] rows;
  logic [KEY_COLS-1:0] cols;
  logic [NUM_KEYS-1:0] matrix;
  logic                frame_done;
  logic                press_strobe;
  logic [CODE_W-1:0]   press_code;

  modport master (
    output rows,
    output matrix,
    output frame_done,
    output press_strobe,
    output press_code,
    input  cols
  );

  modport slave (
    input  rows,
    input  matrix,
    input  frame_done,
    input  press_strobe,
    input  press_code,
    output cols
  );

endinterface

// File: rtl/keypad_debounce.sv
// Per-key frame-count debouncer, matrix register
// and lowest-index press-code priority pick.
module keypad_debounce
  import ghostchip_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] sample,
  input  logic                commit,
  output logic [NUM_KEYS-1:0] matrix,
  output logic                press_strobe,
  output logic [CODE_W-1:0]   press_code
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] matrix_q, matrix_d;
  logic                press_strobe_q, press_strobe_d;
  logic [CODE_W-1:0]   press_code_q, press_code_d;
  logic [NUM_KEYS-1:0] rise;
  logic [CW-1:0]       inc;
  logic [CODE_W-1:0]   pick;

  always_comb begin
    matrix_d = matrix_q;
    cnt_d    = cnt_q;
    inc      = '0;
    pick     = '0;
    if (commit) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (sample[k] == matrix_q[k]) begin
          cnt_d[k] = '0;
        end else begin
          inc = cnt_q[k] + 1'b1;
          if (inc == CW'(DEBOUNCE_SCANS)) begin
            matrix_d[k] = ~matrix_q[k];
            cnt_d[k]    = '0;
          end else begin
            cnt_d[k] = inc;
          end
        end
      end
    end
    rise = matrix_d & ~matrix_q;
    // descending scan so the lowest rising index wins
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rise[k]) pick = CODE_W'(k);
    end
    press_strobe_d = |rise;
    press_code_d   = press_strobe_d ? pick : press_code_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q       <= '0;
      press_strobe_q <= 1'b0;
      press_code_q   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      matrix_q       <= matrix_d;
      press_strobe_q <= press_strobe_d;
      press_code_q   <= press_code_d;
      cnt_q          <= cnt_d;
    end
  end

  assign matrix       = matrix_q;
  assign press_strobe = press_strobe_q;
  assign press_code   = press_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-at-a-time keypad scanner: row FSM, settle
// counter and frame buffer feeding the debouncer.
module keypad_scanner
  import ghostchip_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int SW = $clog2(SETTLE_CYCLES);

  scan_state_e         state_q, state_d;
  logic [ROW_W-1:0]    r_q, r_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [NUM_KEYS-1:0] scan_buf_q, scan_buf_d;
  logic                frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    settle_d     = settle_q;
    scan_buf_d   = scan_buf_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          scan_buf_d[{r_q, 2'b00} +: KEY_COLS] = ~kp.cols;
          settle_d = '0;
          r_d      = r_q + 1'b1;
          if (r_q == ROW_W'(KEY_ROWS - 1)) begin
            state_d      = COMMIT;
            frame_done_d = 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = SCAN;
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      r_q          <= '0;
      settle_q     <= '0;
      scan_buf_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      settle_q     <= settle_d;
      scan_buf_q   <= scan_buf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // released immediately on reset so no row is driven while held
  assign kp.rows       = reset ? '1 : row_drive(r_q);
  assign kp.frame_done = frame_done_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample       (scan_buf_q),
    .commit       (frame_done_q),
    .matrix       (kp.matrix),
    .press_strobe (kp.press_strobe),
    .press_code   (kp.press_code)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a
// frame-timed behavioural keypad/debounce model.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DS     = 3;
  localparam int FRAME  = 4 * SETTLE + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] held = '0;
  int          vectors = 0;
  int          errors = 0;

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (bus)
  );

  always #5 clk = ~clk;

  // keypad: a held key shorts its column low while its row is low
  always_comb begin
    bus.cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!bus.rows[r] && held[r*4+c]) bus.cols[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model, indexed by cycle count since reset
  int          mcyc = 0;
  bit          mvalid = 0;
  logic [15:0] m_buf = '0;
  logic [15:0] m_mat = '0;
  int          m_cnt [16];
  bit          m_strobe = 0;
  logic [3:0]  m_code = '0;

  always @(negedge clk) begin
    int ph;
    int row;
    logic [15:0] nm;
    logic [3:0] er;
    bit found;
    ph  = mcyc % FRAME;
    row = (ph < 4 * SETTLE) ? ph / SETTLE : 0;
    if (mvalid) begin
      er = ~(4'b0001 << row);
      if (reset) er = 4'hF;
      chk("rows", bus.rows, er);
      chk("frame_done", bus.frame_done, ph == 4 * SETTLE);
      chk("matrix", bus.matrix, m_mat);
      chk("press_strobe", bus.press_strobe, m_strobe);
      chk("press_code", bus.press_code, m_code);
    end
    if (reset) begin
      mcyc = 0; mvalid = 1;
      m_buf = '0; m_mat = '0;
      m_strobe = 0; m_code = '0;
      for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    end else begin
      m_strobe = 0;
      if (ph < 4 * SETTLE && ph % SETTLE == SETTLE - 1)
        for (int c = 0; c < 4; c++)
          m_buf[row*4+c] = held[row*4+c];
      if (ph == 4 * SETTLE) begin
        nm = m_mat;
        for (int k = 0; k < 16; k++) begin
          if (m_buf[k] == m_mat[k]) m_cnt[k] = 0;
          else begin
            m_cnt[k]++;
            if (m_cnt[k] == DS) begin
              nm[k] = ~m_mat[k];
              m_cnt[k] = 0;
            end
          end
        end
        found = 0;
        for (int k = 0; k < 16; k++) begin
          if (!found && nm[k] && !m_mat[k]) begin
            found = 1; m_strobe = 1; m_code = 4'(k);
          end
        end
        m_mat = nm;
      end
      mcyc++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done) seen = 1;
    end
    if (!seen) chk("frame_timeout", 16'd1, 16'd0);
    tick(1);
  endtask

  task automatic wait_press(input string tag,
                            input logic [3:0] code,
                            input logic [15:0] mat);
    bit seen = 0;
    for (int i = 0; i < 6 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (bus.press_strobe) seen = 1;
    end
    chk({tag, "_seen"}, 16'(seen), 16'd1);
    chk({tag, "_code"}, bus.press_code, code);
    chk({tag, "_mat"}, bus.matrix, mat);
    tick(1);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(100);
    chk("idle_mat", bus.matrix, 16'h0000);

    held = 16'h0020;
    pulse_reset();
    wait_press("key5", 4'd5, 16'h0020);
    tick(2 * FRAME);
    held = '0;
    tick(4 * FRAME);
    chk("key5_rel", bus.matrix, 16'h0000);

    wait_frame();
    held = 16'h0200; tick(2 * FRAME);
    held = '0;       tick(FRAME);
    held = 16'h0200; tick(2 * FRAME);
    held = '0;       tick(4 * FRAME);
    chk("bounce_mat", bus.matrix, 16'h0000);

    wait_frame();
    held = 16'h1008;
    wait_press("k12_3", 4'd3, 16'h1008);
    held = '0;
    tick(4 * FRAME);

    held = 16'h0001;
    pulse_reset();
    tick(2 * FRAME + 2 * SETTLE + 1);
    pulse_reset();
    chk("midrst_mat", bus.matrix, 16'h0000);
    wait_press("key0", 4'd0, 16'h0001);

    for (int it = 0; it < 40; it++) begin
      held = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) pulse_reset();
      tick($urandom_range(5, 5 * FRAME));
    end
    held = '0;
    tick(5 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a physical 4x4 hex keypad by driving rows one at a time and sensing columns.
- Debounces every key and presents the 16-bit active-high keypad_matrix word that the cpu consumes.
- It is the hardware-input counterpart to matrix_workshop: matrix_workshop synthesises the matrix from emulator switches, while this block recovers it from a real row/column keypad on board builds.
- It also emits a one-cycle key-press strobe with a hex code, used by the cpu's wait-for-key instruction.

Parameters:
- SETTLE_CYCLES, 16: cycles each row is driven before its columns are sampled. Must be >= 2.
- DEBOUNCE_SCANS, 4: consecutive full frames a key must differ from its debounced state before that state flips. Must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rows  out  4  row drive, active-low; exactly one row is low at a time outside reset.
- cols  in  4  column sense, active-low, externally pulled up; treated as already synchronised.
- matrix  out  16  debounced key state, 1 = pressed; bit index = row*4 + col.
- frame_done  out  1  one-cycle pulse when a full 4-row frame is committed to the debounce stage.
- press_strobe  out  1  one-cycle pulse when any debounced bit rises 0->1.
- press_code  out  4  index of the key reported by press_strobe; holds its value between strobes.

Behaviour:
- Dimensions: one clock domain, fully synchronous; the whole block uses a single clock and reset is synchronous and active-high.
- Reset values: rows=4'b1111, matrix=0, frame_done=0, press_strobe=0, press_code=0. Row index r=0, settle counter=0, scan buffer=0, all debounce counters=0.
- Reset mid-frame: any partial frame is discarded; no commit, strobe or matrix change results from it.
- After reset, scanning restarts at row 0 with settle counter 0.
- Scan FSM, two states:
  - SCAN: rows=~(1<<r); the settle counter counts 0..SETTLE_CYCLES-1.
  - When the counter equals SETTLE_CYCLES-1, capture ~cols into scan_buf[r*4 +: 4], reset the counter to 0 and advance r.
  - If r was 3, r wraps to 0 and the FSM enters COMMIT.
  - COMMIT: lasts one cycle, keeps driving row 0 and does not advance the settle counter. frame_done=1 for this cycle. The FSM then returns to SCAN, row 0, counter 0.
  - Frame period: 4*SETTLE_CYCLES+1 cycles.
- Debounce, evaluated for every key k in the COMMIT cycle:
  - If scan_buf[k]==matrix[k], cnt[k] is set to 0.
  - Otherwise cnt[k] increments. When the incremented value equals DEBOUNCE_SCANS, matrix[k] toggles and cnt[k] is set to 0.
  - cnt width is clog2(DEBOUNCE_SCANS+1); cnt never exceeds DEBOUNCE_SCANS.
  - DEBOUNCE_SCANS=1 means the matrix follows each frame directly.
- Latency: matrix updates on the clock edge ending COMMIT, so the new value is visible the cycle after frame_done.
- Press event:
  - In the cycle after COMMIT, press_strobe=1 if any bit rose in that commit.
  - press_code is the lowest rising index. Simultaneous additional rises are not reported separately; they still appear in matrix.
  - Releases (1->0) never strobe.
- Ghosting, multiple keys in one row, and multiple columns active are all passed through unfiltered; anti-ghosting is out of scope.

Decomposition:
- ghostchip_pkg holds KEY_ROWS=4, KEY_COLS=4, NUM_KEYS=16, and the scan-state encoding (SCAN, COMMIT).
- One sub-module, keypad_debounce: the per-key counter bank, the matrix register and press-code priority logic. Its interface is frame sample + commit enable in, matrix/press_strobe/press_code out.
- The scanner top holds the row FSM, settle counter and scan buffer.

Test Plan:
Bench settings: SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, frame = 17 cycles. The keypad model pulls cols[c] low only while its row is low and the key is held.
- Reset, then idle 100 cycles -> rows cycles 1110,1101,1011,0111, each row held 4 cycles; frame_done pulses every 17 cycles; matrix=0; no strobe.
- Hold key 5 (row1,col1) from reset release -> matrix=16'h0020 appears the cycle after the 3rd frame_done; press_strobe=1 for exactly one cycle with press_code=5.
- Release key 5 -> matrix[5] clears after 3 more frame commits; press_strobe stays 0.
- Bounce key 9: pressed for 2 frames, released 1, pressed 2, released -> matrix stays 0 and no strobe.
- Press keys 12 and 3 together -> matrix=16'h1008 after the 3rd commit; a single strobe with press_code=3.
- Hold key 0; assert reset for 1 cycle mid-row-2 of frame 3 -> rows=1111 during reset, matrix=0; after reset the scan resumes at row 0; matrix[0] sets after 3 new commits.
